// File: rtl/vote_lamp_decoder.sv
// vote_lamp_decoder: registered 4-to-16 lamp decoder with hold, lockout gap and done/drop pulses.
// Optional LAMP_CHECK_EN adds a sticky re-encode self-check on lamp_out.
module vote_lamp_decoder #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  code_in,
  input  logic        code_valid,
  input  logic        abort,
  output logic [15:0] lamp_out,
  output logic        busy,
  output logic        done,
  output logic        drop,
  output logic        check_err
);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] code, code_n;
  logic [15:0] lamp_n;
  logic accept, last, to_gap, done_n, drop_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      code <= '0;
      lamp_out <= '0;
      done <= 1'b0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      code <= code_n;
      lamp_out <= lamp_n;
      done <= done_n;
      drop <= drop_n;
    end
  end
  always_comb begin
    accept = state == IDLE && code_valid && !abort;
    last = cnt == '0;
    to_gap = state == HOLD && GAP_CYCLES > 0;
    state_n = state == IDLE ? (accept ? HOLD : IDLE)
            : abort ? IDLE
            : !last ? state
            : to_gap ? GAP : IDLE;
  end
  // counter is reloaded on every transition, so it never underflows
  always_comb begin
    cnt_n = accept ? CNT_W'(HOLD_CYCLES - 1)
          : (state == IDLE || abort) ? '0
          : !last ? cnt - 1'b1
          : to_gap ? CNT_W'(GAP_CYCLES - 1) : '0;
    code_n = accept ? code_in : code;
    lamp_n = state_n == HOLD ? 16'h1 << code_n : 16'h0;
    done_n = state != IDLE && state_n == IDLE && !abort;
    drop_n = code_valid && state != IDLE;
  end
  assign busy = state != IDLE;
`ifdef LAMP_CHECK_EN
  logic [3:0] idx;
  logic hot, err_n;
  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++) idx = lamp_out[i] ? 4'(i) : idx;
    hot = $onehot(lamp_out);
    err_n = state == HOLD ? (!hot || idx != code) : lamp_out != '0;
  end
  always_ff @(posedge clk) check_err <= rst ? 1'b0 : check_err | err_n;
`else
  assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_vote_lamp_decoder.sv
// tb_vote_lamp_decoder: directed checks of vote_lamp_decoder (default and GAP_CYCLES=0 instances).
module tb_vote_lamp_decoder;
  logic clk = 0, rst = 1, code_valid = 0, abort = 0;
  logic [3:0] code_in = 0;
  logic [15:0] lamp0, lamp1;
  logic busy0, done0, drop0, err0, busy1, done1, drop1, err1;
  int checks = 0, errors = 0;

  vote_lamp_decoder u0 (.clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .abort(abort), .lamp_out(lamp0), .busy(busy0), .done(done0), .drop(drop0), .check_err(err0));
  vote_lamp_decoder #(.GAP_CYCLES(0)) u1 (.clk(clk), .rst(rst), .code_in(code_in),
    .code_valid(code_valid), .abort(abort), .lamp_out(lamp1), .busy(busy1), .done(done1),
    .drop(drop1), .check_err(err1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [15:0] lamp, input logic b, input logic d, input logic dr);
    chk({tag, "_lamp"}, lamp0, lamp);
    chk({tag, "_busy"}, busy0, b);
    chk({tag, "_done"}, done0, d);
    chk({tag, "_drop"}, drop0, dr);
  endtask

  task automatic run_vote(input int n);
    logic [15:0] exp_lamp;
    exp_lamp = 16'h1 << n;
    code_in = 4'(n);
    code_valid = 1;
    tick();
    code_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("sweep_hold", lamp0, exp_lamp);
      chk("sweep_hold_busy", busy0, 1'b1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk0("sweep_gap", 16'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk0("sweep_done", 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    chk0("reset", 16'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_err", err0, 1'b0);
    rst = 0;
    // single vote, code 5
    code_in = 4'd5;
    code_valid = 1;
    tick();
    code_valid = 0;
    chk0("v5_first", 16'h0020, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk0("v5_last_lit", 16'h0020, 1'b1, 1'b0, 1'b0);
    tick();
    chk0("v5_gap_start", 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk0("v5_gap_end", 16'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk0("v5_done", 16'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk0("v5_after", 16'h0, 1'b0, 1'b0, 1'b0);
    // full sweep, each code issued on the previous done cycle
    for (int n = 0; n < 16; n++) run_vote(n);
    chk("sweep_err", err0, 1'b0);
    // requests while busy
    code_in = 4'd3;
    code_valid = 1;
    tick();
    code_valid = 0;
    chk0("rb_c1", 16'h0008, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    code_in = 4'd9;
    code_valid = 1;
    tick();
    code_valid = 0;
    chk0("rb_drop1", 16'h0008, 1'b1, 1'b0, 1'b1);
    tick();
    chk0("rb_c5", 16'h0008, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk0("rb_c8", 16'h0008, 1'b1, 1'b0, 1'b0);
    tick();
    chk0("rb_gap", 16'h0, 1'b1, 1'b0, 1'b0);
    code_valid = 1;
    tick();
    code_valid = 0;
    chk0("rb_drop2", 16'h0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk0("rb_c12", 16'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk0("rb_done", 16'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk0("rb_idle", 16'h0, 1'b0, 1'b0, 1'b0);
    // abort mid-hold
    code_in = 4'd15;
    code_valid = 1;
    tick();
    code_valid = 0;
    chk0("ab_c1", 16'h8000, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk0("ab_after", 16'h0, 1'b0, 1'b0, 1'b0);
    code_in = 4'd0;
    code_valid = 1;
    tick();
    code_valid = 0;
    chk0("ab_reaccept", 16'h0001, 1'b1, 1'b0, 1'b0);
    // reset mid-gap
    for (int i = 0; i < 8; i++) tick();
    chk0("rg_gap", 16'h0, 1'b1, 1'b0, 1'b0);
    rst = 1;
    tick();
    rst = 0;
    chk0("rg_reset", 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk0("rg_no_done", 16'h0, 1'b0, 1'b0, 1'b0);
    // abort with valid in idle
    abort = 1;
    code_valid = 1;
    code_in = 4'd6;
    tick();
    abort = 0;
    code_valid = 0;
    chk0("av_idle", 16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk0("av_idle2", 16'h0, 1'b0, 1'b0, 1'b0);
    chk("final_err", err0, 1'b0);
    // GAP_CYCLES=0 instance, code_valid held high
    rst = 1;
    tick();
    rst = 0;
    chk("g0_reset_lamp", lamp1, 16'h0);
    code_in = 4'd7;
    code_valid = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("g0_lit", lamp1, 16'h0080);
      chk("g0_busy", busy1, 1'b1);
      chk("g0_nodone", done1, 1'b0);
    end
    tick();
    chk("g0_dark", lamp1, 16'h0);
    chk("g0_dark_busy", busy1, 1'b0);
    chk("g0_done", done1, 1'b1);
    tick();
    chk("g0_relit", lamp1, 16'h0080);
    chk("g0_relit_busy", busy1, 1'b1);
    chk("g0_relit_done", done1, 1'b0);
    chk("g0_err", err1, 1'b0);
    code_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
